// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM type and register map of the MMIO UART.
// Imported by the FIFO-backed transmitter and its bus decode.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam logic [2:0] OFS_DATA   = 3'd0;
  localparam logic [2:0] OFS_STATUS = 3'd4;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers and count.
// Head entry is presented combinationally on dout.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: 8N1 UART transmitter on the dmem bus.
// Stores to DATA queue bytes; loads from STATUS report state.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLK_HZ     = 27_000_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);

  if (DIV < 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      BASE_ADDR[2:0] != 3'b000) begin : g_bad_cfg
    $error("uart_tx_mmio: illegal parameter set");
  end

  uart_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          pop;
  logic          ovf;
  logic          is_stat;
  logic          push_req;
  logic          clr_ovf;
  logic [7:0]    dout;
  logic          full;
  logic          empty;
  logic [AW:0]   fifo_cnt;
  logic [31:0]   status;
  logic          unused_bits;

  assign hit         = a[31:3] == BASE_ADDR[31:3];
  assign is_stat     = a[2] == OFS_STATUS[2];
  assign push_req    = we & hit & (a[2] == OFS_DATA[2]);
  assign clr_ovf     = we & hit & is_stat & wd[ST_OVF];
  assign unused_bits = ^{wd[31:8], a[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (wd[7:0]),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  // Overflow is sticky until software writes STATUS bit3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (push_req && full) ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = dout;
          cnt_n   = CW'(DIV - 1);
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          cnt_n   = CW'(DIV - 1);
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n   = CW'(DIV - 1);
          shift_n = shift >> 1;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STOP: begin
        // Chain straight into the next start bit when data waits.
        if (cnt == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_n = dout;
            cnt_n   = CW'(DIV - 1);
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (1'b1)
      state == START: tx = 1'b0;
      state == DATA:  tx = shift[0];
      default:        tx = 1'b1;
    endcase
  end

  assign irq = empty & (state == IDLE);

  always_comb begin
    status               = '0;
    status[ST_BUSY]      = state != IDLE;
    status[ST_FULL]      = full;
    status[ST_EMPTY]     = empty;
    status[ST_OVF]       = ovf;
    status[ST_CNT +: 8]  = 8'(fifo_cnt);
  end

  assign rd = (hit && is_stat) ? status : '0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: random and directed stimulus with a byte
// scoreboard fed by a FIFO/timing model and a serial receiver.
module tb_uart_tx_mmio;

  localparam int DIV   = 8;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * DIV;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        hit;
  logic        tx;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .CLK_HZ     (8),
    .BAUD       (1),
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .hit   (hit),
    .tx    (tx),
    .irq   (irq)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: FIFO occupancy plus "transmitter free at" time.
  int cyc = 0;
  int occ = 0;
  int busy_until = 0;
  bit m_ovf = 1'b0;
  logic [7:0] exp_q[$];

  function automatic bit in_win(input logic [31:0] ad);
    return ad[31:3] == BASE[31:3];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit pop_now;
    bit acc;
    if (!rst_n) begin
      occ = 0;
      busy_until = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      pop_now = (occ > 0) && (cyc >= busy_until);
      acc = 1'b0;
      if (we && in_win(a) && !a[2]) begin
        if (occ < DEPTH) begin
          acc = 1'b1;
          exp_q.push_back(wd[7:0]);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (we && in_win(a) && a[2] && wd[3]) m_ovf = 1'b0;
      occ = occ + int'(acc) - int'(pop_now);
      if (pop_now) busy_until = cyc + FRAME;
    end
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = cyc < busy_until;
    s[1] = occ == DEPTH;
    s[2] = occ == 0;
    s[3] = m_ovf;
    s[15:8] = 8'(occ);
    return s;
  endfunction

  // Monitor: 8N1 receiver sampling mid-bit, pops the scoreboard.
  bit rx_on = 1'b0;
  int rx_ph = 0;
  logic tx_prev = 1'b1;
  logic [7:0] rx_b = '0;
  int frames = 0;
  int starts = 0;
  int start_cyc[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_on = 1'b0;
      tx_prev = 1'b1;
    end else begin
      if (!rx_on) begin
        if (tx_prev && !tx) begin
          rx_on = 1'b1;
          rx_ph = 0;
          starts++;
          start_cyc.push_back(cyc);
        end
      end else begin
        rx_ph++;
        if (rx_ph == DIV / 2) begin
          chk("start_bit", 32'(tx), 32'd0);
        end else if (rx_ph == 9 * DIV + DIV / 2) begin
          chk("stop_bit", 32'(tx), 32'd1);
          frames++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got 0x%02h want none", rx_b);
          end else begin
            chk("rx_byte", 32'(rx_b), 32'(exp_q.pop_front()));
          end
          rx_on = 1'b0;
        end else if (rx_ph % DIV == DIV / 2) begin
          rx_b[rx_ph / DIV - 1] = tx;
        end
      end
      tx_prev = tx;
    end
  end

  task automatic drive(input logic [31:0] ad, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    a = ad;
    wd = d;
  endtask

  task automatic idle();
    @(negedge clk);
    we = 1'b0;
    a = '0;
    wd = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] ad,
                        input logic [31:0] exp);
    @(negedge clk);
    we = 1'b0;
    a = ad;
    #1;
    chk(nm, rd, exp);
  endtask

  task automatic rd_stat(input string nm);
    @(negedge clk);
    we = 1'b0;
    a = BASE + 32'd4;
    #1;
    chk(nm, rd, exp_status());
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((occ != 0 || cyc < busy_until || rx_on) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles want <%0d", n, budget);
    end
  endtask

  initial begin
    int f0;
    int s0;
    int r;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("rst_status", BASE + 32'd4, 32'h0000_0004);

    // Single byte: latency, framing, idle state afterwards.
    drive(BASE, 32'h55);
    idle();
    chk("lat_edge1", 32'(tx), 32'd1);
    @(negedge clk);
    chk("lat_edge2", 32'(tx), 32'd0);
    repeat (FRAME - 1) @(negedge clk);
    chk("irq_busy", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_done", 32'(irq), 32'd1);
    rd_chk("status_done", BASE + 32'd4, 32'h0000_0004);

    // Back-to-back frames.
    s0 = start_cyc.size();
    drive(BASE, 32'h41);
    drive(BASE, 32'h42);
    idle();
    repeat (3) @(negedge clk);
    rd_stat("b2b_status");
    chk("b2b_count", 32'(rd[15:8]), 32'd1);
    drain(400);
    chk("b2b_frames", 32'(start_cyc.size() - s0), 32'd2);
    if (start_cyc.size() >= s0 + 2)
      chk("b2b_gap", 32'(start_cyc[s0+1] - start_cyc[s0]), 32'(FRAME));

    // Overflow: 18 stores into a 16-deep FIFO.
    f0 = frames;
    for (int i = 0; i < 18; i++) drive(BASE, 32'(8'h10 + i));
    idle();
    rd_stat("ovf_status");
    chk("ovf_bit3", 32'(rd[3]), 32'd1);
    chk("ovf_bit1", 32'(rd[1]), 32'd1);
    drive(BASE + 32'd4, 32'h8);
    idle();
    rd_stat("ovf_clr_status");
    chk("ovf_clr_bit3", 32'(rd[3]), 32'd0);
    drain(3000);
    chk("ovf_frames", 32'(frames - f0), 32'd17);

    // Asynchronous reset during data bit 3 of 0xA5.
    s0 = starts;
    drive(BASE, 32'hA5);
    idle();
    @(negedge clk);
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    chk("mid_bit3", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("arst_status", BASE + 32'd4, 32'h0000_0004);
    repeat (2 * FRAME) @(negedge clk);
    chk("arst_no_frame", 32'(starts - s0), 32'd1);

    // Outside the window and the DATA register read.
    rd_chk("miss_rd", BASE + 32'd8, 32'd0);
    chk("miss_hit", 32'(hit), 32'd0);
    s0 = starts;
    drive(BASE + 32'd8, 32'hFF);
    idle();
    rd_chk("miss_status", BASE + 32'd4, 32'h0000_0004);
    repeat (20) @(negedge clk);
    chk("miss_tx", 32'(tx), 32'd1);
    chk("miss_no_frame", 32'(starts - s0), 32'd0);
    rd_chk("data_rd", BASE, 32'd0);
    chk("data_hit", 32'(hit), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        drive(BASE, $urandom);
        if ($urandom_range(0, 1) == 1) idle();
      end else if (r == 6) begin
        rd_stat("rnd_status");
      end else if (r == 7) begin
        drive(BASE + 32'd4, $urandom);
        idle();
      end else if (r == 8) begin
        drive(BASE + 32'd8 + 32'($urandom_range(0, 7)), $urandom);
        idle();
      end else begin
        idle();
        repeat ($urandom_range(20, 120)) @(negedge clk);
      end
    end
    idle();
    rd_stat("rnd_status_end");
    drain(6000);
    rd_stat("final_status");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
